// File: rtl/filter_coef_loader.sv
// Coefficient loader for a chain of filter step blocks.
// Words arrive tap by tap over a valid/ready stream into a shadow bank. A complete
// set is copied into the active bank in one edge at a sample boundary (ena high), so
// the filter never sees a mix of old and new coefficients. Short or long sets are
// discarded and flagged with a one-cycle err pulse.
module filter_coef_loader #(
  parameter int unsigned WIDTH_B = 32,
  parameter int unsigned TAPS    = 8,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [WIDTH_B-1:0]      s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [TAPS*WIDTH_B-1:0] b_out,
  output logic                    loaded,
  output logic                    err,
  output logic                    busy
);

  typedef enum logic [1:0] {StLoad, StDrain, StPend} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       count_q;
  logic                   loaded_q;
  logic                   err_q;
  logic [WIDTH_B-1:0]     shadow_q [TAPS];
  logic [TAPS*WIDTH_B-1:0] active_q;

  logic accept;
  logic last_tap;
  logic swap;
  logic shadow_we;

  // Ready depends on state only, so a source may wait on it before raising valid.
  assign s_ready   = (state_q != StPend);
  assign accept    = s_valid & s_ready;
  assign last_tap  = (count_q == CNT_W'(TAPS - 1));
  assign swap      = (state_q == StPend) & ena;
  assign shadow_we = (state_q == StLoad) & accept;

  assign b_out  = active_q;
  assign loaded = loaded_q;
  assign err    = err_q;
  assign busy   = (state_q != StLoad) | (count_q != '0);

  // Set framing FSM with registered status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StLoad;
      count_q  <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        StLoad: begin
          if (accept) begin
            if (last_tap) begin
              count_q <= '0;
              // Exactly TAPS words ends the set; anything more is drained.
              state_q <= s_last ? StPend : StDrain;
            end else if (s_last) begin
              // Short set: shadow is left dirty but never reaches the active bank.
              count_q <= '0;
              err_q   <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (accept && s_last) begin
            err_q   <= 1'b1;
            state_q <= StLoad;
          end
        end
        StPend: begin
          if (ena) begin
            loaded_q <= 1'b1;
            state_q  <= StLoad;
          end
        end
        default: begin
          state_q <= StLoad;
          count_q <= '0;
        end
      endcase
    end
  end

  // Shadow bank: one tap written per accepted word while loading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[count_q] <= s_data;
    end
  end

  // Active bank: whole-set copy from shadow on the sample boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
    end else if (swap) begin
      for (int k = 0; k < TAPS; k++) begin
        active_q[k*WIDTH_B +: WIDTH_B] <= shadow_q[k];
      end
    end
  end

endmodule
